// File: rtl/conv_line_sequencer.sv
// conv_line_sequencer
// Turns a raster pixel stream into 3-pixel vertical columns {row y-2, row y-1, row y}
// for a 3x3 convolution datapath. Two line buffers hold the previous two rows. Rows 0
// and 1 of every frame only prime the buffers. From row 2 on, each accepted pixel
// produces one column on the next cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame in progress; the next valid pixel is taken as (0,0)
// FILL  | rows 0 and 1: line buffers are being primed, no output
// RUN   | rows 2..HEIGHT-1: one column per accepted pixel
module conv_line_sequencer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DW     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_valid,
    input  logic            i_sof,
    input  logic [DW-1:0]   i_data,
    output logic            o_valid,
    output logic [3*DW-1:0] o_data,
    output logic            o_edge,
    output logic            o_img_done,
    output logic            o_busy
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;

    logic [DW-1:0]   lb_a_q [WIDTH];
    logic [DW-1:0]   lb_b_q [WIDTH];

    logic            valid_q, valid_d;
    logic [3*DW-1:0] data_q, data_d;
    logic            edge_q, edge_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    // Position of the current pixel: a start-of-frame marker, or any pixel arriving
    // while idle, is forced to (0,0) so that the frame realigns to it.
    logic          restart;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          row_end;
    logic          frame_end;

    // Resolve the pixel position and advance the raster counters
    always_comb begin
        restart   = i_valid && (i_sof || (state_q == S_IDLE));
        px        = restart ? '0 : x_q;
        py        = restart ? '0 : y_q;
        row_end   = (px == X_LAST);
        frame_end = row_end && (py == Y_LAST);
        x_d       = x_q;
        y_d       = y_q;
        if (i_valid) begin
            if (row_end) begin
                x_d = '0;
                y_d = frame_end ? '0 : py + 1'b1;
            end else begin
                x_d = px + 1'b1;
                y_d = py;
            end
        end
    end

    // State and raster counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        if (i_valid) begin
            if (restart) begin
                state_d = S_FILL;
            end else begin
                case (state_q)
                    S_FILL:  if (row_end && (py == Y_ONE)) state_d = S_RUN;
                    S_RUN:   if (frame_end) state_d = S_IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Output decode: a column is emitted only for a regular pixel in RUN; the
    // column fields hold their previous values otherwise.
    always_comb begin
        valid_d = i_valid && !restart && (state_q == S_RUN);
        data_d  = data_q;
        edge_d  = edge_q;
        done_d  = done_q;
        if (valid_d) begin
            data_d = {lb_a_q[px], lb_b_q[px], i_data};
            edge_d = (px < X_TWO);
            done_d = frame_end;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            edge_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            edge_q  <= edge_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Line buffers shift down one row per accepted pixel; no reset because every
    // entry is rewritten during FILL before RUN ever reads it.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            lb_a_q[px] <= lb_b_q[px];
            lb_b_q[px] <= i_data;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_edge     = edge_q;
    assign o_img_done = done_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_conv_line_sequencer.sv
// Directed bench for conv_line_sequencer at WIDTH=4, HEIGHT=4, DW=8 with pixel
// value 16*y + x, so every expected column is {16(y-2)+x, 16(y-1)+x, 16y+x}.
module tb_conv_line_sequencer;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic        i_sof;
    logic [7:0]  i_data;
    logic        o_valid;
    logic [23:0] o_data;
    logic        o_edge;
    logic        o_img_done;
    logic        o_busy;

    int n_cmp = 0;
    int n_err = 0;

    // Values the outputs are expected to hold while no column is produced
    logic [23:0] h_data;
    logic        h_edge;
    logic        h_done;
    logic        h_busy;

    conv_line_sequencer #(.WIDTH(4), .HEIGHT(4), .DW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_sof      (i_sof),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_edge     (o_edge),
        .o_img_done (o_img_done),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_data"},  32'(o_data), 32'd0);
        check({tag, "_edge"},  32'(o_edge), 32'd0);
        check({tag, "_done"},  32'(o_img_done), 32'd0);
        check({tag, "_busy"},  32'(o_busy), 32'd0);
    endtask

    // Present pixel (x,y) of the current frame and check the cycle that follows
    task automatic pix(input int x, input int y, input bit sof, output bit got);
        logic ev;
        @(negedge clk);
        i_valid = 1'b1;
        i_sof   = sof;
        i_data  = 8'(16 * y + x);
        @(posedge clk);
        #1;
        ev = (y >= 2);
        if (ev) begin
            h_data = {8'(16 * (y - 2) + x), 8'(16 * (y - 1) + x), 8'(16 * y + x)};
            h_edge = (x < 2);
            h_done = (x == 3) && (y == 3);
        end
        h_busy = !((x == 3) && (y == 3));
        got    = o_valid;
        check("valid", 32'(o_valid), 32'(ev));
        check("data",  32'(o_data), 32'(h_data));
        check("edge",  32'(o_edge), 32'(h_edge));
        check("done",  32'(o_img_done), 32'(h_done));
        check("busy",  32'(o_busy), 32'(h_busy));
        if (x == 0 && y == 2) check("col_0_2", 32'(o_data), 32'h00_0010_20);
        if (x == 3 && y == 3) check("col_3_3", 32'(o_data), 32'h00_1323_33);
    endtask

    // One cycle without a pixel: no column, everything else holds
    task automatic idle();
        @(negedge clk);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_data  = 8'($urandom);
        @(posedge clk);
        #1;
        check("gap_valid", 32'(o_valid), 32'd0);
        check("gap_data",  32'(o_data), 32'(h_data));
        check("gap_edge",  32'(o_edge), 32'(h_edge));
        check("gap_done",  32'(o_img_done), 32'(h_done));
        check("gap_busy",  32'(o_busy), 32'(h_busy));
    endtask

    // Full 16-pixel frame, optionally with random 1-3 cycle gaps between pixels
    task automatic frame(input bit sof_first, input bit gaps);
        bit got;
        int idx;
        int first;
        int cols;
        idx   = 0;
        first = -1;
        cols  = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                pix(x, y, sof_first && (x == 0) && (y == 0), got);
                if (got) begin
                    cols++;
                    if (first < 0) first = idx;
                end
                idx++;
                if (gaps && ($urandom_range(1, 0) == 1)) begin
                    repeat ($urandom_range(3, 1)) idle();
                end
            end
        end
        check("frame_cols",  32'(cols), 32'd8);
        check("frame_first", 32'(first), 32'd8);
    endtask

    initial begin
        bit got;
        reset   = 1'b0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_data  = 8'h00;
        h_data  = 24'h0;
        h_edge  = 1'b0;
        h_done  = 1'b0;
        h_busy  = 1'b0;

        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle();

        // Contiguous frame, then two idle cycles
        frame(1'b1, 1'b0);
        idle();
        idle();

        // Gapped frame whose first pixel carries no start-of-frame marker
        frame(1'b0, 1'b1);

        // Two frames back to back with no gap
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);

        // Abort at pixel (1,2): up to (0,2), then a marked pixel restarts the frame
        for (int i = 0; i < 9; i++) pix(i % 4, i / 4, i == 0, got);
        frame(1'b1, 1'b0);

        // Reset asserted while pixel (2,3) is on the input
        for (int i = 0; i < 14; i++) pix(i % 4, i / 4, 1'b0, got);
        @(negedge clk);
        i_valid = 1'b1;
        i_sof   = 1'b0;
        i_data  = 8'h32;
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        @(posedge clk);
        #1;
        check_outputs_zero("held_rst");
        @(negedge clk);
        i_valid = 1'b0;
        reset   = 1'b1;
        h_data  = 24'h0;
        h_edge  = 1'b0;
        h_done  = 1'b0;
        h_busy  = 1'b0;
        idle();
        frame(1'b0, 1'b0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_line_sequencer.md
CONV_LINE_SEQUENCER -- requirements
Module: conv_line_sequencer

Interface
REQ-001 Parameter WIDTH, default 640, pixels per image row (>=3).
REQ-002 Parameter HEIGHT, default 480, rows per image (>=3).
REQ-003 Parameter DW, default 8, bits per pixel.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 i_valid  input  1  i_data carries one raster-order pixel this cycle.
REQ-007 i_sof  input  1  qualified by i_valid; marks the pixel as row 0, col 0 of a new frame.
REQ-008 i_data  input  DW  pixel value.
REQ-009 o_valid  output  1  o_data holds one 3-pixel column for the convolution datapath.
REQ-010 o_data  output  3*DW  column {row y-2, row y-1, row y}, oldest row in the MSBs.
REQ-011 o_edge  output  1  qualified by o_valid; column index <2, so the 3x3 window spans a row wrap.
REQ-012 o_img_done  output  1  qualified by o_valid; last column of the frame.
REQ-013 o_busy  output  1  high in states FILL and RUN.

Function
REQ-014 The block SHALL hold two line buffers of WIDTH x DW: LB_A for row y-2 and LB_B for row y-1.
REQ-015 It SHALL keep column counter x (0..WIDTH-1) and row counter y (0..HEIGHT-1), both advanced only on i_valid.
REQ-016 x SHALL wrap from WIDTH-1 to 0 and increment y; after (WIDTH-1, HEIGHT-1) both SHALL return to 0.
REQ-017 State machine: IDLE, FILL, RUN.
REQ-018 IDLE -> FILL on the first i_valid; that pixel SHALL be taken as (0,0) whether or not i_sof is set.
REQ-019 FILL covers rows 0 and 1, and FILL -> RUN on the i_valid pixel at (WIDTH-1, 1).
REQ-020 RUN -> IDLE on the i_valid pixel at (WIDTH-1, HEIGHT-1).
REQ-021 On every accepted pixel at column x: LB_A[x] <= LB_B[x] and LB_B[x] <= i_data, both reads using pre-write contents.
REQ-022 In RUN, each accepted pixel SHALL produce o_valid exactly 1 cycle later with o_data = {LB_A[x], LB_B[x], i_data} (pre-write values).
REQ-023 In IDLE and FILL, o_valid SHALL be 0; line buffers SHALL still be written in FILL.
REQ-024 o_edge SHALL equal (x<2) for the pixel that produced the column.
REQ-025 o_img_done SHALL be 1 only with the column from pixel (WIDTH-1, HEIGHT-1).
REQ-026 Cycles without i_valid SHALL hold counters, state and buffers, and SHALL drive o_valid=0 on the next cycle.
REQ-027 o_data, o_edge and o_img_done SHALL hold their last values while o_valid=0.
REQ-028 i_sof with i_valid in any state SHALL resync: the pixel becomes (0,0), state FILL, and it is written to LB_B[0]; prior row data is stale and unused.
REQ-029 i_sof in RUN SHALL suppress the output for that pixel (o_valid=0 next cycle), and o_img_done SHALL NOT be raised for the aborted frame.
REQ-030 Back-to-back frames SHALL be accepted with zero gap: the pixel after (WIDTH-1, HEIGHT-1) starts FILL directly.
REQ-031 o_busy SHALL be a registered decode of the state.
REQ-032 Throughput SHALL be one pixel per cycle with no backpressure; there is no ready signal.

Reset
REQ-033 Reset low SHALL asynchronously force state IDLE and x=y=0.
REQ-034 Reset low SHALL asynchronously clear o_valid, o_edge, o_img_done, o_busy and o_data to 0.
REQ-035 Line buffer contents SHALL NOT require reset; no output SHALL depend on them before they are written in the current frame.
REQ-036 Reset asserted mid-frame SHALL discard the frame; after release, the first i_valid is (0,0).

Verification (WIDTH=4, HEIGHT=4, DW=8, pixel value = 16*y + x)
REQ-037 Stream 16 contiguous pixels -> first 8 cycles o_valid=0, then 8 columns.
REQ-038 For the same stream, column from pixel (0,2) = {0x00,0x10,0x20} with o_edge=1, and pixel (3,3) = {0x13,0x23,0x33} with o_img_done=1 on the last column only.
REQ-039 Insert i_valid=0 gaps of 1-3 cycles randomly -> identical column sequence, and o_valid is never asserted during a gap's following cycle.
REQ-040 Two frames back-to-back, no gap -> second frame outputs after exactly 8 further pixels, and its values match frame 1's pattern.
REQ-041 Assert i_sof on pixel (1,2) -> o_valid=0 for that pixel, then FILL for 8 pixels, and no o_img_done for the aborted frame.
REQ-042 Pull reset low at pixel (2,3) -> all outputs 0 asynchronously, and the next full frame produces correct columns.
